// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder: adds CHUNK bits per clock, carry rippled through a register.
// Define CHUNKED_ADDER_OVF_EN to add the registered signed-overflow output.
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             carry
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cry_q, cry_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef CHUNKED_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;

    // Select the operand chunk addressed by the counter
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        cry_d   = cry_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = A;
                    b_d     = B;
                    cry_d   = cin;
                    cnt_d   = '0;
                    s_d     = '0;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef CHUNKED_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                for (int unsigned k = 0; k < NCHUNK; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        s_d[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                cry_d = chunk_sum[CHUNK];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    carry_d = chunk_sum[CHUNK];
                    done_d  = 1'b1;
                    state_d = StDone;
`ifdef CHUNKED_ADDER_OVF_EN
                    // Carry into the MSB is recovered as a ^ b ^ sum at that bit
                    ovf_d = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1]
                          ^ chunk_sum[CHUNK];
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cry_q   <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cry_q   <= cry_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign S     = s_q;
    assign carry = carry_q;
`ifdef CHUNKED_ADDER_OVF_EN
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: four instances (8/4, 16/1, 16/4, 16/16) driven with directed and
// random operations, checked against a plain-arithmetic model of {carry,S} = A+B+cin.
module tb_chunked_adder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_cin;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [3:0]  carry;
    logic [3:0]  ovf;
    logic [7:0]  s0;
    logic [15:0] s1, s2, s3;

    int checks;
    int failures;

    chunked_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .A(op_a[7:0]), .B(op_b[7:0]),
        .cin(op_cin), .busy(busy[0]), .done(done[0]), .S(s0), .carry(carry[0])
`ifdef CHUNKED_ADDER_OVF_EN
        , .overflow(ovf[0])
`endif
    );
    chunked_adder #(.WIDTH(16), .CHUNK(1)) u_w16c1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .A(op_a), .B(op_b),
        .cin(op_cin), .busy(busy[1]), .done(done[1]), .S(s1), .carry(carry[1])
`ifdef CHUNKED_ADDER_OVF_EN
        , .overflow(ovf[1])
`endif
    );
    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .A(op_a), .B(op_b),
        .cin(op_cin), .busy(busy[2]), .done(done[2]), .S(s2), .carry(carry[2])
`ifdef CHUNKED_ADDER_OVF_EN
        , .overflow(ovf[2])
`endif
    );
    chunked_adder #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .A(op_a), .B(op_b),
        .cin(op_cin), .busy(busy[3]), .done(done[3]), .S(s3), .carry(carry[3])
`ifdef CHUNKED_ADDER_OVF_EN
        , .overflow(ovf[3])
`endif
    );

`ifndef CHUNKED_ADDER_OVF_EN
    assign ovf = '0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int idx);
        return (idx == 0) ? 8 : 16;
    endfunction

    function automatic int nchunk_of(input int idx);
        case (idx)
            0:       return 2;
            1:       return 16;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic sample(input int idx, output logic bz, output logic dn, output logic [15:0] s,
                          output logic cy, output logic ov);
        bz = busy[idx];
        dn = done[idx];
        cy = carry[idx];
        ov = ovf[idx];
        case (idx)
            0:       s = {8'h00, s0};
            1:       s = s1;
            2:       s = s2;
            default: s = s3;
        endcase
    endtask

    task automatic check_reset(input string tag);
        logic bz, dn, cy, ov;
        logic [15:0] s;
        for (int i = 0; i < 4; i++) begin
            sample(i, bz, dn, s, cy, ov);
            check($sformatf("%s_busy%0d", tag, i), bz, 0);
            check($sformatf("%s_done%0d", tag, i), dn, 0);
            check($sformatf("%s_s%0d", tag, i), s, 0);
            check($sformatf("%s_carry%0d", tag, i), cy, 0);
`ifdef CHUNKED_ADDER_OVF_EN
            check($sformatf("%s_ovf%0d", tag, i), ov, 0);
`endif
        end
    endtask

    // One full operation on instance idx, starting and ending on a falling edge
    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
        int w, lat;
        int unsigned sum;
        logic [15:0] mask, am, bm, es, s;
        logic ec, eo, bz, dn, cy, ov;
        w    = width_of(idx);
        mask = (w == 8) ? 16'h00FF : 16'hFFFF;
        am   = a & mask;
        bm   = b & mask;
        sum  = 32'(am) + 32'(bm) + 32'(c);
        es   = 16'(sum) & mask;
        ec   = ((sum >> w) & 1) != 0;
        eo   = (am[w-1] == bm[w-1]) && (es[w-1] != am[w-1]);

        op_a = a; op_b = b; op_cin = c; start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); op_cin = 1'($urandom);
        sample(idx, bz, dn, s, cy, ov);
        check("accept_busy", bz, 1);
        check("accept_done", dn, 0);
        check("accept_s", s, 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            sample(idx, bz, dn, s, cy, ov);
            if (!dn) check("run_busy", bz, 1);
        end while (!dn && lat < 64);
        check($sformatf("latency%0d", idx), lat, nchunk_of(idx));
        check($sformatf("sum%0d a=%0h b=%0h c=%0d", idx, am, bm, c), s, es);
        check($sformatf("carry%0d", idx), cy, ec);
        check("done_busy", bz, 0);
`ifdef CHUNKED_ADDER_OVF_EN
        check($sformatf("ovf%0d a=%0h b=%0h", idx, am, bm), ov, eo);
`endif
        @(negedge clk);
        sample(idx, bz, dn, s, cy, ov);
        check("idle_done", dn, 0);
        check("hold_s", s, es);
        check("hold_carry", cy, ec);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bz, dn, cy, ov;
        logic [15:0] s;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = '0;
        op_a     = '0;
        op_b     = '0;
        op_cin   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 16'h0012, 16'h0034, 1'b0);
        do_op(0, 16'h00FF, 16'h0001, 1'b0);
        do_op(0, 16'h00FF, 16'h00FF, 1'b1);

        // Back-to-back with start held high; operand changes during RUN must not matter
        op_a = 16'h0012; op_b = 16'h0034; op_cin = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        op_a = 16'h000F; op_b = 16'h0001;
        @(negedge clk);
        sample(0, bz, dn, s, cy, ov);
        check("b2b_run_busy", bz, 1);
        check("b2b_run_done", dn, 0);
        @(negedge clk);
        sample(0, bz, dn, s, cy, ov);
        check("b2b_done1", dn, 1);
        check("b2b_s1", s, 16'h0046);
        check("b2b_carry1", cy, 0);
        @(negedge clk);
        sample(0, bz, dn, s, cy, ov);
        check("b2b_accept_done", dn, 0);
        check("b2b_accept_busy", bz, 1);
        check("b2b_accept_s", s, 0);
        op_a = 16'h0077; op_b = 16'h0077;
        @(negedge clk);
        start[0] = 1'b0;
        sample(0, bz, dn, s, cy, ov);
        check("midrun_busy", bz, 1);
        check("midrun_done", dn, 0);
        @(negedge clk);
        sample(0, bz, dn, s, cy, ov);
        check("b2b_done2", dn, 1);
        check("b2b_s2", s, 16'h0010);
        check("b2b_carry2", cy, 0);
        @(negedge clk);
        sample(0, bz, dn, s, cy, ov);
        check("midrun_ignored_busy", bz, 0);
        check("midrun_ignored_s", s, 16'h0010);

        // Asynchronous reset while two instances are mid-RUN
        op_a = 16'hFFFF; op_b = 16'h0000; op_cin = 1'b0; start = 4'b0011;
        @(negedge clk);
        start = '0;
        @(negedge clk);
        sample(0, bz, dn, s, cy, ov);
        check("partial_s0", s, 16'h000F);
        sample(1, bz, dn, s, cy, ov);
        check("partial_s1", s, 16'h0001);
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(0, 16'h0005, 16'h0003, 1'b0);

        // Signed-overflow corners (S/carry checked in every build)
        do_op(0, 16'h007F, 16'h0001, 1'b0);
        do_op(0, 16'h0080, 16'h0080, 1'b0);
        do_op(0, 16'h0010, 16'h0020, 1'b0);

        for (int i = 1; i < 4; i++) do_op(i, 16'hFFFF, 16'h0001, 1'b0);

        for (int n = 0; n < 200; n++) begin
            for (int i = 1; i < 4; i++) begin
                do_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
            end
        end
        for (int n = 0; n < 50; n++) begin
            do_op(0, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
